// File: rtl/fifo_flow_if.sv
// Handshake bundle for fifo_flow: producer and consumer sides plus fill-level status.
// The FIFO takes the slave modport; whatever drives and consumes it takes master.
interface fifo_flow_if #(
   parameter int unsigned NUM   = 8,
   parameter int unsigned WIDTH = 32
);
   localparam int unsigned CW = $clog2(NUM + 1);

   logic             IN_flush;
   logic [WIDTH-1:0] IN_data;
   logic             IN_valid;
   logic             OUT_ready;
   logic             IN_ready;
   logic             OUT_valid;
   logic [WIDTH-1:0] OUT_data;
   logic [CW-1:0]    OUT_count;
   logic             OUT_almostFull;

   modport master (
      output IN_flush, IN_data, IN_valid, IN_ready,
      input  OUT_ready, OUT_valid, OUT_data, OUT_count, OUT_almostFull
   );

   modport slave (
      input  IN_flush, IN_data, IN_valid, IN_ready,
      output OUT_ready, OUT_valid, OUT_data, OUT_count, OUT_almostFull
   );
endinterface

// File: rtl/fifo_flow.sv
// First-word-fall-through FIFO of any depth: memory ring feeding a registered head entry,
// with occupancy count, almost-full flag and synchronous flush.
module fifo_flow #(
   parameter int unsigned NUM   = 8,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AFULL = NUM - 1
) (
   input logic        clk,
   input logic        rst_n,
   fifo_flow_if.slave bus
);
   localparam int unsigned PW = $clog2(NUM);
   localparam int unsigned CW = $clog2(NUM + 1);
   localparam logic [CW-1:0] NUM_C    = CW'(NUM);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL);
   localparam logic [PW-1:0] LAST_PTR = PW'(NUM - 1);

   logic [WIDTH-1:0] mem [NUM];

   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   logic push, pop, ring_empty, load, bypass, mem_wr, mem_rd;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   assign push = bus.IN_valid && (count_q != NUM_C);
   assign pop  = valid_q && bus.IN_ready;

   // Ring occupancy is count minus the entry parked in the output register.
   assign ring_empty = (count_q == {{(CW-1){1'b0}}, valid_q});
   assign load       = !valid_q || pop;
   assign bypass     = push && ring_empty && load;
   assign mem_wr     = push && !bypass && !bus.IN_flush;
   assign mem_rd     = load && !ring_empty;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      valid_d = valid_q;
      data_d  = data_q;
      if (bus.IN_flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         valid_d = 1'b0;
      end else begin
         if (mem_wr) wptr_d = ptr_inc(wptr_q);
         if (mem_rd) begin
            rptr_d  = ptr_inc(rptr_q);
            data_d  = mem[rptr_q];
            valid_d = 1'b1;
         end else if (bypass) begin
            data_d  = bus.IN_data;
            valid_d = 1'b1;
         end else if (load) begin
            valid_d = 1'b0;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (mem_wr) mem[wptr_q] <= bus.IN_data;
   end

   assign bus.OUT_ready      = (count_q != NUM_C);
   assign bus.OUT_valid      = valid_q;
   assign bus.OUT_data       = data_q;
   assign bus.OUT_count      = count_q;
   assign bus.OUT_almostFull = (count_q >= AFULL_C);
endmodule

// File: tb/tb_fifo_flow.sv
// Self-checking bench for fifo_flow: queue reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_fifo_flow;
   localparam int unsigned NUM   = 5;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned AFULL = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   fifo_flow_if #(.NUM(NUM), .WIDTH(WIDTH)) bus ();

   fifo_flow #(.NUM(NUM), .WIDTH(WIDTH), .AFULL(AFULL)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   bit model_on = 1'b0;
   logic [WIDTH-1:0] model_q[$];
   logic [WIDTH-1:0] sent[$];
   logic [WIDTH-1:0] got[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: contents as a queue, head at index 0.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_q.delete();
      end else begin
         bit m_push, m_pop;
         m_push = bus.IN_valid && (model_q.size() != NUM);
         m_pop  = bus.IN_ready && (model_q.size() != 0);
         if (bus.IN_flush) begin
            model_q.delete();
         end else begin
            if (m_pop) void'(model_q.pop_front());
            if (m_push) model_q.push_back(bus.IN_data);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && model_on) begin
         chk("m_valid", 32'(bus.OUT_valid), 32'(model_q.size() != 0));
         chk("m_count", 32'(bus.OUT_count), 32'(model_q.size()));
         chk("m_ready", 32'(bus.OUT_ready), 32'(model_q.size() != NUM));
         chk("m_afull", 32'(bus.OUT_almostFull), 32'(model_q.size() >= AFULL));
         chk("m_known", 32'($isunknown(bus.OUT_data)), 32'(0));
         if (model_q.size() != 0) chk("m_data", 32'(bus.OUT_data), 32'(model_q[0]));
      end
   end

   initial begin
      bus.IN_flush = 1'b0;
      bus.IN_valid = 1'b0;
      bus.IN_ready = 1'b0;
      bus.IN_data  = '0;
      #2;
      chk("rst_valid", 32'(bus.OUT_valid), 32'(0));
      chk("rst_count", 32'(bus.OUT_count), 32'(0));
      chk("rst_ready", 32'(bus.OUT_ready), 32'(1));
      chk("rst_afull", 32'(bus.OUT_almostFull), 32'(0));
      chk("rst_data", 32'(bus.OUT_data), 32'(0));
      #10;
      rst_n = 1'b1;
      model_on = 1'b1;

      // Fill to capacity with the consumer stalled; sixth push must bounce.
      for (int i = 0; i < 6; i++) begin
         bus.IN_valid = 1'b1;
         bus.IN_data  = WIDTH'(8'h11 + i);
         step();
         if (i < 5) begin
            chk("fill_count", 32'(bus.OUT_count), 32'(i + 1));
            chk("fill_valid", 32'(bus.OUT_valid), 32'(1));
            chk("fill_head", 32'(bus.OUT_data), 32'h11);
            chk("fill_afull", 32'(bus.OUT_almostFull), 32'(i + 1 >= 3));
            chk("fill_ready", 32'(bus.OUT_ready), 32'(i + 1 != 5));
         end else begin
            chk("full_count", 32'(bus.OUT_count), 32'(5));
            chk("full_ready", 32'(bus.OUT_ready), 32'(0));
         end
      end

      // Drain in order.
      bus.IN_valid = 1'b0;
      bus.IN_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("drain_data", 32'(bus.OUT_data), 32'(8'h11 + i));
         step();
      end
      chk("drain_valid", 32'(bus.OUT_valid), 32'(0));
      chk("drain_count", 32'(bus.OUT_count), 32'(0));

      // Back-to-back streaming across several pointer wraps.
      for (int k = 0; k < 24; k++) begin
         if (k < 23) begin
            bus.IN_valid = 1'b1;
            bus.IN_data  = WIDTH'($urandom);
            sent.push_back(bus.IN_data);
         end else begin
            bus.IN_valid = 1'b0;
         end
         if (bus.OUT_valid) got.push_back(bus.OUT_data);
         step();
         if (k < 23) chk("stream_count", 32'(bus.OUT_count), 32'(1));
      end
      chk("stream_len", 32'(got.size()), 32'(23));
      for (int i = 0; i < 23; i++) begin
         if (i < got.size()) chk("stream_data", 32'(got[i]), 32'(sent[i]));
      end
      chk("stream_empty", 32'(bus.OUT_count), 32'(0));
      bus.IN_ready = 1'b0;

      // Almost-full threshold.
      for (int i = 0; i < 3; i++) begin
         bus.IN_valid = 1'b1;
         bus.IN_data  = WIDTH'(8'h31 + i);
         step();
         chk("af_flag", 32'(bus.OUT_almostFull), 32'(i == 2));
      end
      bus.IN_valid = 1'b0;
      bus.IN_ready = 1'b1;
      step();
      bus.IN_ready = 1'b0;
      chk("af_count", 32'(bus.OUT_count), 32'(2));
      chk("af_clear", 32'(bus.OUT_almostFull), 32'(0));

      // Flush beats a simultaneous push and pop.
      bus.IN_valid = 1'b1;
      bus.IN_data  = 8'h34;
      step();
      chk("pre_flush", 32'(bus.OUT_count), 32'(3));
      bus.IN_flush = 1'b1;
      bus.IN_ready = 1'b1;
      bus.IN_data  = 8'hEE;
      step();
      bus.IN_flush = 1'b0;
      bus.IN_valid = 1'b0;
      bus.IN_ready = 1'b0;
      chk("flush_count", 32'(bus.OUT_count), 32'(0));
      chk("flush_valid", 32'(bus.OUT_valid), 32'(0));
      chk("flush_ready", 32'(bus.OUT_ready), 32'(1));
      bus.IN_valid = 1'b1;
      bus.IN_data  = 8'h5A;
      step();
      bus.IN_valid = 1'b0;
      chk("post_flush_data", 32'(bus.OUT_data), 32'h5A);
      chk("post_flush_count", 32'(bus.OUT_count), 32'(1));
      bus.IN_ready = 1'b1;
      step();
      bus.IN_ready = 1'b0;

      // Asynchronous reset pulse between edges with four entries held.
      for (int i = 0; i < 4; i++) begin
         bus.IN_valid = 1'b1;
         bus.IN_data  = WIDTH'(8'h61 + i);
         step();
      end
      bus.IN_valid = 1'b0;
      chk("pre_rst_count", 32'(bus.OUT_count), 32'(4));
      #1 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.OUT_valid), 32'(0));
      chk("arst_count", 32'(bus.OUT_count), 32'(0));
      chk("arst_data", 32'(bus.OUT_data), 32'(0));
      chk("arst_afull", 32'(bus.OUT_almostFull), 32'(0));
      #1 rst_n = 1'b1;
      bus.IN_valid = 1'b1;
      bus.IN_data  = 8'hAA;
      step();
      bus.IN_valid = 1'b0;
      chk("arst_first_valid", 32'(bus.OUT_valid), 32'(1));
      chk("arst_first_data", 32'(bus.OUT_data), 32'hAA);
      bus.IN_ready = 1'b1;
      step();

      // Randomized traffic with varying consumer pressure.
      for (int ep = 0; ep < 4; ep++) begin
         for (int c = 0; c < 150; c++) begin
            bus.IN_valid = ($urandom_range(0, 3) != 0);
            bus.IN_ready = ($urandom_range(0, 3) < ep + 1) && ($urandom_range(0, 1) == 1 || ep == 3);
            bus.IN_flush = ($urandom_range(0, 49) == 0);
            bus.IN_data  = WIDTH'($urandom);
            step();
         end
      end
      bus.IN_valid = 1'b0;
      bus.IN_flush = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
